// File: rtl/tpu_instr_sequencer.sv
// TPU instruction sequencer: accepts packed instructions over valid/ready and expands
// each legal datapath instruction into single-cycle address beats.
module tpu_instr_sequencer #(
    parameter int BUF_AW  = 24,
    parameter int ACC_AW  = 16,
    parameter int LEN_W   = 32,
    parameter int MAX_ACT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [79:0]       instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic              stall_i,
    input  logic              resume_i,
    output logic              weight_en_o,
    output logic              matmul_en_o,
    output logic              act_en_o,
    output logic [3:0]        act_func_o,
    output logic [BUF_AW-1:0] buf_addr_o,
    output logic [ACC_AW-1:0] acc_addr_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              err_illegal_o,
    output logic [31:0]       instr_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP     = 3'd0,
        CL_WEIGHT  = 3'd1,
        CL_MATMUL  = 3'd2,
        CL_ACT     = 3'd3,
        CL_HALT    = 3'd4,
        CL_ILLEGAL = 3'd5
    } op_class_t;

    localparam logic [1:0] KIND_WEIGHT = 2'd0;
    localparam logic [1:0] KIND_MATMUL = 2'd1;
    localparam logic [1:0] KIND_ACT    = 2'd2;

    // Activation codes above MAX_ACT are treated the same as unknown opcodes.
    function automatic op_class_t classify(input logic [7:0] op);
        op_class_t cls;
        case (op)
            8'h00:   cls = CL_NOP;
            8'h01:   cls = CL_WEIGHT;
            8'h02:   cls = CL_MATMUL;
            8'hFF:   cls = CL_HALT;
            default: begin
                if ((op[7:4] == 4'h8) && (int'(op[3:0]) <= MAX_ACT)) begin
                    cls = CL_ACT;
                end else begin
                    cls = CL_ILLEGAL;
                end
            end
        endcase
        return cls;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    op_class_t         op_cls_s;
    logic              accept_s;
    logic              start_s;
    logic              beat_s;
    logic              last_beat_s;
    logic              count_inc_s;
    logic [LEN_W-1:0]  len_in_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  cnt_r;
    logic [1:0]        kind_r;
    logic [3:0]        act_func_r;
    logic [BUF_AW-1:0] buf_addr_r;
    logic [ACC_AW-1:0] acc_addr_r;
    logic              err_r;
    logic [31:0]       count_r;

    // Decode of the offered instruction and of the current beat.
    always_comb begin
        op_cls_s    = classify(instr_i[7:0]);
        len_in_s    = instr_i[8 +: LEN_W];
        accept_s    = instr_valid_i && (state_r == ST_IDLE);
        start_s     = 1'b0;
        if ((op_cls_s == CL_WEIGHT) || (op_cls_s == CL_MATMUL) || (op_cls_s == CL_ACT)) begin
            start_s = accept_s && (len_in_s != {LEN_W{1'b0}});
        end else begin
            start_s = 1'b0;
        end
        beat_s      = (state_r == ST_ISSUE) && !stall_i;
        last_beat_s = (cnt_r == (len_r - LEN_W'(1)));
        // Zero-length legal ops, NOP and HALT complete at acceptance; others on their last beat.
        count_inc_s = (accept_s && !start_s && (op_cls_s != CL_ILLEGAL))
                      || (beat_s && last_beat_s);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (op_cls_s == CL_HALT)) begin
                    state_next_s = ST_HALTED;
                end else if (start_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (beat_s && last_beat_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_HALTED: begin
                if (resume_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction latch, beat counter, address generators, error flag and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r      <= {LEN_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
            kind_r     <= KIND_WEIGHT;
            act_func_r <= 4'd0;
            buf_addr_r <= {BUF_AW{1'b0}};
            acc_addr_r <= {ACC_AW{1'b0}};
            err_r      <= 1'b0;
            count_r    <= 32'd0;
        end else begin
            if (start_s) begin
                len_r      <= len_in_s;
                cnt_r      <= {LEN_W{1'b0}};
                buf_addr_r <= instr_i[56 +: BUF_AW];
                acc_addr_r <= instr_i[40 +: ACC_AW];
                case (op_cls_s)
                    CL_WEIGHT: kind_r <= KIND_WEIGHT;
                    CL_MATMUL: kind_r <= KIND_MATMUL;
                    CL_ACT:    kind_r <= KIND_ACT;
                    default:   kind_r <= KIND_WEIGHT;
                endcase
                act_func_r <= (op_cls_s == CL_ACT) ? instr_i[3:0] : 4'd0;
            end else if (beat_s) begin
                cnt_r      <= cnt_r + LEN_W'(1);
                buf_addr_r <= buf_addr_r + BUF_AW'(1);
                acc_addr_r <= acc_addr_r + ACC_AW'(1);
                if (last_beat_s) begin
                    act_func_r <= 4'd0;
                end
            end
            if (accept_s && (op_cls_s == CL_ILLEGAL)) begin
                err_r <= 1'b1;
            end
            if (count_inc_s) begin
                count_r <= count_r + 32'd1;
            end
        end
    end

    assign instr_ready_o = (state_r == ST_IDLE);
    assign busy_o        = (state_r != ST_IDLE);
    assign halted_o      = (state_r == ST_HALTED);
    assign weight_en_o   = beat_s && (kind_r == KIND_WEIGHT);
    assign matmul_en_o   = beat_s && (kind_r == KIND_MATMUL);
    assign act_en_o      = beat_s && (kind_r == KIND_ACT);
    assign last_o        = beat_s && last_beat_s;
    assign act_func_o    = act_func_r;
    assign buf_addr_o    = buf_addr_r;
    assign acc_addr_o    = acc_addr_r;
    assign err_illegal_o = err_r;
    assign instr_count_o = count_r;

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Bench for tpu_instr_sequencer: directed scenarios then random traffic, checked every cycle
// against a queue-based model of the expected beat stream.
module tb_tpu_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic [79:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        stall_i;
    logic        resume_i;
    logic        weight_en_o;
    logic        matmul_en_o;
    logic        act_en_o;
    logic [3:0]  act_func_o;
    logic [23:0] buf_addr_o;
    logic [15:0] acc_addr_o;
    logic        last_o;
    logic        busy_o;
    logic        halted_o;
    logic        err_illegal_o;
    logic [31:0] instr_count_o;

    tpu_instr_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .stall_i       (stall_i),
        .resume_i      (resume_i),
        .weight_en_o   (weight_en_o),
        .matmul_en_o   (matmul_en_o),
        .act_en_o      (act_en_o),
        .act_func_o    (act_func_o),
        .buf_addr_o    (buf_addr_o),
        .acc_addr_o    (acc_addr_o),
        .last_o        (last_o),
        .busy_o        (busy_o),
        .halted_o      (halted_o),
        .err_illegal_o (err_illegal_o),
        .instr_count_o (instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] baddr;
        logic [15:0] aaddr;
        logic        last;
        logic [3:0]  act;
    } beat_t;

    beat_t       exp_q[$];
    int          mode;
    logic [31:0] m_count;
    logic        m_err;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] mk(input logic [23:0] b, input logic [15:0] a,
                                       input logic [31:0] len, input logic [7:0] op);
        return {b, a, len, op};
    endfunction

    task automatic check_outputs(input logic st);
        beat_t b;
        check("ready",  64'(instr_ready_o), 64'(mode == 0));
        check("busy",   64'(busy_o),        64'(mode != 0));
        check("halted", 64'(halted_o),      64'(mode == 2));
        check("err",    64'(err_illegal_o), 64'(m_err));
        check("count",  64'(instr_count_o), 64'(m_count));
        if (mode == 1 && !st) begin
            b = exp_q[0];
            check("weight_en", 64'(weight_en_o), 64'(b.kind == 2'd0));
            check("matmul_en", 64'(matmul_en_o), 64'(b.kind == 2'd1));
            check("act_en",    64'(act_en_o),    64'(b.kind == 2'd2));
            check("buf_addr",  64'(buf_addr_o),  64'(b.baddr));
            check("acc_addr",  64'(acc_addr_o),  64'(b.aaddr));
            check("last",      64'(last_o),      64'(b.last));
            check("act_func",  64'(act_func_o),  64'(b.act));
        end else begin
            check("enables_idle", 64'({weight_en_o, matmul_en_o, act_en_o, last_o}), 64'd0);
        end
    endtask

    // Model of what the upcoming rising edge does, expressed as instruction semantics.
    task automatic model_edge(input logic v, input logic [79:0] ins, input logic st, input logic rs);
        logic [7:0]  op;
        logic [31:0] len;
        logic [1:0]  kind;
        logic        legal_data;
        beat_t       b;
        op  = ins[7:0];
        len = ins[39:8];
        if (mode == 0 && v) begin
            legal_data = 1'b1;
            kind = 2'd0;
            if (op == 8'h01) kind = 2'd0;
            else if (op == 8'h02) kind = 2'd1;
            else if (op[7:4] == 4'h8 && op[3:0] <= 4'd10) kind = 2'd2;
            else legal_data = 1'b0;
            if (op == 8'h00) begin
                m_count++;
            end else if (op == 8'hFF) begin
                m_count++;
                mode = 2;
            end else if (!legal_data) begin
                m_err = 1'b1;
            end else if (len == 32'd0) begin
                m_count++;
            end else begin
                for (int i = 0; i < int'(len); i++) begin
                    b.kind  = kind;
                    b.baddr = ins[79:56] + 24'(i);
                    b.aaddr = ins[55:40] + 16'(i);
                    b.last  = (i == int'(len) - 1);
                    b.act   = (kind == 2'd2) ? op[3:0] : 4'd0;
                    exp_q.push_back(b);
                end
                mode = 1;
            end
        end else if (mode == 1 && !st) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                m_count++;
                mode = 0;
            end
        end else if (mode == 2 && rs) begin
            mode = 0;
        end
    endtask

    task automatic step(input logic v, input logic [79:0] ins, input logic st, input logic rs);
        @(negedge clk);
        instr_valid_i = v;
        instr_i       = ins;
        stall_i       = st;
        resume_i      = rs;
        #1;
        check_outputs(st);
        model_edge(v, ins, st, rs);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 80'd0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = 80'd0;
        stall_i       = 1'b0;
        resume_i      = 1'b0;
        #1;
        exp_q.delete();
        mode    = 0;
        m_count = 32'd0;
        m_err   = 1'b0;
        check_outputs(1'b0);
        check("rst_buf", 64'(buf_addr_o), 64'd0);
        check("rst_act", 64'(act_func_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  op;
        logic [79:0] ins;
        int          guard;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        instr_valid_i = 1'b0;
        instr_i = 80'd0;
        stall_i = 1'b0;
        resume_i = 1'b0;
        apply_reset();
        idle_steps(1);

        // MATMUL len 3, no stall, then bubble
        step(1'b1, mk(24'h000100, 16'h0010, 32'd3, 8'h02), 1'b0, 1'b0);
        idle_steps(4);
        check("count_after_matmul", 64'(instr_count_o), 64'd1);

        // WEIGHT_LOAD len 4 with stall on beat cycles 2-3
        step(1'b1, mk(24'h00A000, 16'h0200, 32'd4, 8'h01), 1'b0, 1'b0);
        step(1'b0, 80'd0, 1'b0, 1'b0);
        step(1'b0, 80'd0, 1'b1, 1'b0);
        step(1'b0, 80'd0, 1'b1, 1'b0);
        idle_steps(4);

        // Address wrap
        step(1'b1, mk(24'hFFFFFF, 16'hFFFF, 32'd2, 8'h02), 1'b0, 1'b0);
        idle_steps(3);

        // Activation, illegal activation, zero length
        step(1'b1, mk(24'h000050, 16'h0005, 32'd1, 8'h83), 1'b0, 1'b0);
        idle_steps(2);
        step(1'b1, mk(24'h000050, 16'h0005, 32'd2, 8'h8B), 1'b0, 1'b0);
        idle_steps(2);
        step(1'b1, mk(24'h000050, 16'h0005, 32'd0, 8'h02), 1'b0, 1'b0);
        idle_steps(1);

        // HALT with valid held, then resume
        step(1'b1, mk(24'd0, 16'd0, 32'd0, 8'hFF), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, mk(24'h10, 16'h1, 32'd1, 8'h01), 1'b0, 1'b0);
        step(1'b1, mk(24'h10, 16'h1, 32'd1, 8'h01), 1'b0, 1'b1);
        step(1'b1, mk(24'h10, 16'h1, 32'd1, 8'h01), 1'b0, 1'b0);
        idle_steps(3);

        // Reset in the middle of a MATMUL
        step(1'b1, mk(24'h000300, 16'h0030, 32'd6, 8'h02), 1'b0, 1'b0);
        idle_steps(2);
        apply_reset();
        idle_steps(1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0:       op = 8'h00;
                1, 2:    op = 8'h01;
                3, 4:    op = 8'h02;
                5, 6:    op = {4'h8, 4'($urandom_range(0, 15))};
                7:       op = 8'hFF;
                default: op = 8'($urandom_range(0, 255));
            endcase
            ins = mk(24'($urandom()), 16'($urandom()), 32'($urandom_range(0, 6)), op);
            step(1'($urandom_range(0, 9) < 7), ins, 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 9) < 2));
        end

        guard = 0;
        while (mode != 0 && guard < 50) begin
            step(1'b0, 80'd0, 1'b0, 1'b1);
            guard++;
        end
        check("drain_done", 64'(mode), 64'd0);
        idle_steps(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
